spell_sequencer: RTL and testbench

SPELL_SEQUENCER -- requirements
Module: spell_sequencer

---
 rtl/spell_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_spell_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spell_sequencer.sv
// rtl/spell_sequencer.sv - fetch/execute sequencer for the spell byte-code engine
// Optional build macro: SPELL_STACK_CHECK_EN (stack overflow/underflow fault detection).
// Execute logic is external: this block owns pc, sp, the 32-entry stack and the
// fetch / memory-write / delay / sleep handshakes around each opcode.

module spell_sequencer #(
    parameter int unsigned DELAY_PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       wake,
    output logic       fetch_req,
    input  logic       fetch_ack,
    input  logic [7:0] fetch_data,
    output logic [7:0] opcode,
    output logic [7:0] pc,
    output logic [4:0] sp,
    output logic [7:0] stack_top,
    output logic [7:0] stack_belowtop,
    input  logic [7:0] exec_next_pc,
    input  logic [4:0] exec_next_sp,
    input  logic [1:0] exec_stack_write_count,
    input  logic [7:0] exec_set_stack_top,
    input  logic [7:0] exec_set_stack_belowtop,
    input  logic       exec_mem_wr_en,
    input  logic       exec_sleep,
    input  logic       exec_stop,
    input  logic [7:0] exec_delay,
    output logic       mem_wr_req,
    input  logic       mem_wr_ack,
    output logic       halted,
    output logic       stack_err
);

    typedef enum logic [2:0] {
        ST_HALT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEMWR = 3'd3,
        ST_DELAY = 3'd4,
        ST_SLEEP = 3'd5
    } state_t;

    // 8-bit delay units times a 16-bit prescale fits in 24 bits
    localparam int          CNT_W    = 24;
    localparam logic [15:0] PRESCALE = 16'(DELAY_PRESCALE);

    state_t             state_q;
    state_t             state_d;
    state_t             tail_state_d;
    state_t             exec_state_d;
    logic [7:0]         pc_q;
    logic [4:0]         sp_q;
    logic [7:0]         opcode_q;
    logic [CNT_W-1:0]   delay_cnt_q;
    logic [CNT_W-1:0]   delay_load_d;
    logic               fetch_req_q;
    logic               mem_wr_req_q;
    logic               halted_q;
    logic               stack_fault;
    logic [7:0]         stack_q [32];
    logic [4:0]         top_idx;
    logic [4:0]         below_idx;
    logic [4:0]         wr_top_idx;
    logic [4:0]         wr_below_idx;

    // Stack indices wrap naturally in 5 bits
    assign top_idx      = sp_q - 5'd1;
    assign below_idx    = sp_q - 5'd2;
    assign wr_top_idx   = exec_next_sp - 5'd1;
    assign wr_below_idx = exec_next_sp - 5'd2;

    assign stack_top      = stack_q[top_idx];
    assign stack_belowtop = stack_q[below_idx];

    assign delay_load_d = CNT_W'(exec_delay) * CNT_W'(PRESCALE);

`ifdef SPELL_STACK_CHECK_EN
    assign stack_fault = ((sp_q == 5'd31) && (exec_next_sp == 5'd0)) ||
                         ((sp_q < 5'd2) && (exec_next_sp >= 5'd30));
`else
    assign stack_fault = 1'b0;
`endif

    // Post-commit routing shared by EXEC and the end of MEMWR (memory write excluded)
    always_comb begin
        tail_state_d = ST_FETCH;
        if (exec_stop) begin
            tail_state_d = ST_HALT;
        end else if (exec_delay != 8'd0) begin
            tail_state_d = ST_DELAY;
        end else if (exec_sleep) begin
            tail_state_d = ST_SLEEP;
        end else if (!run) begin
            tail_state_d = ST_HALT;
        end
    end

    // Full EXEC routing: stop beats memory write, which beats everything else
    always_comb begin
        exec_state_d = tail_state_d;
        if (exec_stop) begin
            exec_state_d = ST_HALT;
        end else if (exec_mem_wr_en) begin
            exec_state_d = ST_MEMWR;
        end
    end

    // Next-state selection for the sequencer FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT:  if (run)       state_d = ST_FETCH;
            ST_FETCH: if (fetch_ack) state_d = ST_EXEC;
            ST_EXEC:  state_d = stack_fault ? ST_HALT : exec_state_d;
            ST_MEMWR: if (mem_wr_ack) state_d = tail_state_d;
            ST_DELAY: if (delay_cnt_q <= CNT_W'(1)) state_d = run ? ST_FETCH : ST_HALT;
            ST_SLEEP: if (wake)      state_d = ST_FETCH;
            default:  state_d = ST_HALT;
        endcase
    end

    // FSM state, architectural registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_HALT;
            pc_q         <= 8'd0;
            sp_q         <= 5'd0;
            opcode_q     <= 8'hFF;
            delay_cnt_q  <= '0;
            fetch_req_q  <= 1'b0;
            mem_wr_req_q <= 1'b0;
            halted_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            fetch_req_q  <= (state_d == ST_FETCH);
            mem_wr_req_q <= (state_d == ST_MEMWR);
            halted_q     <= (state_d == ST_HALT);
            case (state_q)
                ST_FETCH: begin
                    if (fetch_ack) begin
                        opcode_q <= fetch_data;
                    end
                end
                ST_EXEC: begin
                    if (!stack_fault) begin
                        pc_q <= exec_next_pc;
                        sp_q <= exec_next_sp;
                        if (state_d == ST_DELAY) begin
                            delay_cnt_q <= delay_load_d;
                        end
                    end
                end
                ST_MEMWR: begin
                    if (mem_wr_ack && (state_d == ST_DELAY)) begin
                        delay_cnt_q <= delay_load_d;
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_q != '0) begin
                        delay_cnt_q <= delay_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SPELL_STACK_CHECK_EN
    logic stack_err_q;

    // Sticky fault flag: set by a faulting EXEC, cleared on reset or on restart from HALT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stack_err_q <= 1'b0;
        end else if ((state_q == ST_EXEC) && stack_fault) begin
            stack_err_q <= 1'b1;
        end else if ((state_q == ST_HALT) && run) begin
            stack_err_q <= 1'b0;
        end
    end

    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

    // Stack storage is not reset; up to two slots written at EXEC commit
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_EXEC) && !stack_fault) begin
            if (exec_stack_write_count != 2'd0) begin
                stack_q[wr_top_idx] <= exec_set_stack_top;
            end
            if (exec_stack_write_count == 2'd2) begin
                stack_q[wr_below_idx] <= exec_set_stack_belowtop;
            end
        end
    end

    assign fetch_req  = fetch_req_q;
    assign mem_wr_req = mem_wr_req_q;
    assign halted     = halted_q;
    assign opcode     = opcode_q;
    assign pc         = pc_q;
    assign sp         = sp_q;

endmodule

// File: tb/tb_spell_sequencer.sv
// tb/tb_spell_sequencer.sv - directed bench for spell_sequencer with a tiny execute model

module tb_spell_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       wake;
    logic       fetch_req;
    logic       fetch_ack;
    logic [7:0] fetch_data;
    logic [7:0] opcode;
    logic [7:0] pc;
    logic [4:0] sp;
    logic [7:0] stack_top;
    logic [7:0] stack_belowtop;
    logic [7:0] e_next_pc;
    logic [4:0] e_next_sp;
    logic [1:0] e_cnt;
    logic [7:0] e_top;
    logic [7:0] e_below;
    logic       e_mem;
    logic       e_sleep;
    logic       e_stop;
    logic [7:0] e_delay;
    logic       mem_wr_req;
    logic       mem_wr_ack;
    logic       halted;
    logic       stack_err;
    logic       ack_en;
    logic [7:0] prog [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign fetch_ack  = fetch_req & ack_en;
    assign fetch_data = prog[pc];

    // Execute stage: '+' add, '!' store (pop 2), 'd' delay 3, 'z' sleep, 0xFF stop, others push
    always_comb begin
        e_next_pc = pc + 8'd1;
        e_next_sp = sp;
        e_cnt     = 2'd0;
        e_top     = 8'd0;
        e_below   = 8'd0;
        e_mem     = 1'b0;
        e_sleep   = 1'b0;
        e_stop    = 1'b0;
        e_delay   = 8'd0;
        case (opcode)
            8'h2B: begin
                e_next_sp = sp - 5'd1;
                e_cnt     = 2'd1;
                e_top     = stack_belowtop + stack_top;
            end
            8'h21: begin
                e_mem     = 1'b1;
                e_next_sp = sp - 5'd2;
            end
            8'h64: e_delay = 8'd3;
            8'h7A: e_sleep = 1'b1;
            8'hFF: e_stop  = 1'b1;
            default: begin
                e_next_sp = sp + 5'd1;
                e_cnt     = 2'd1;
                e_top     = opcode;
            end
        endcase
    end

    spell_sequencer #(.DELAY_PRESCALE(16)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .run                     (run),
        .wake                    (wake),
        .fetch_req               (fetch_req),
        .fetch_ack               (fetch_ack),
        .fetch_data              (fetch_data),
        .opcode                  (opcode),
        .pc                      (pc),
        .sp                      (sp),
        .stack_top               (stack_top),
        .stack_belowtop          (stack_belowtop),
        .exec_next_pc            (e_next_pc),
        .exec_next_sp            (e_next_sp),
        .exec_stack_write_count  (e_cnt),
        .exec_set_stack_top      (e_top),
        .exec_set_stack_belowtop (e_below),
        .exec_mem_wr_en          (e_mem),
        .exec_sleep              (e_sleep),
        .exec_stop               (e_stop),
        .exec_delay              (e_delay),
        .mem_wr_req              (mem_wr_req),
        .mem_wr_ack              (mem_wr_ack),
        .halted                  (halted),
        .stack_err               (stack_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] b4);
        for (int i = 0; i < 256; i++) prog[i] = 8'hFF;
        prog[0] = b0;
        prog[1] = b1;
        prog[2] = b2;
        prog[3] = b3;
        prog[4] = b4;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        run        = 1'b0;
        wake       = 1'b0;
        mem_wr_ack = 1'b0;
        ack_en     = 1'b1;
        step(2);
        rst_n      = 1'b1;
    endtask

    initial begin
        int n;
        logic moved;
        logic left;

        // Addition program, reset values, stop and resume
        load_prog(8'h35, 8'h33, 8'h2B, 8'hFF, 8'h37);
        rst_n = 1'b0; run = 1'b0; wake = 1'b0; mem_wr_ack = 1'b0; ack_en = 1'b1;
        step(2);
        check_eq("rst_halted", halted, 1);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_sp", sp, 0);
        check_eq("rst_opcode", opcode, 8'hFF);
        check_eq("rst_fetch_req", fetch_req, 0);
        check_eq("rst_mem_wr_req", mem_wr_req, 0);
        check_eq("rst_stack_err", stack_err, 0);
        rst_n = 1'b1;
        wake = 1'b1;
        step(1);
        wake = 1'b0;
        check_eq("wake_in_halt", halted, 1);
        run = 1'b1;
        step(7);
        check_eq("add_pc", pc, 3);
        check_eq("add_sp", sp, 1);
        check_eq("add_top", stack_top, 8'h68);
        check_eq("add_fetch_req", fetch_req, 1);
        run = 1'b0;
        step(2);
        check_eq("stop_halted", halted, 1);
        check_eq("stop_pc", pc, 4);
        check_eq("stop_opcode", opcode, 8'hFF);
        step(5);
        check_eq("stop_pc_hold", pc, 4);
        check_eq("stop_fetch_idle", fetch_req, 0);
        run = 1'b1;
        step(1);
        check_eq("resume_halted", halted, 0);
        check_eq("resume_fetch_req", fetch_req, 1);
        step(2);
        check_eq("resume_sp", sp, 2);
        check_eq("resume_top", stack_top, 8'h37);
        check_eq("resume_below", stack_belowtop, 8'h68);
        check_eq("resume_pc", pc, 5);
        run = 1'b0;
        step(3);

        // Store with memory-write ack three cycles late
        load_prog(8'h11, 8'h40, 8'h21, 8'hFF, 8'hFF);
        do_reset();
        run = 1'b1;
        step(6);
        check_eq("st_pre_sp", sp, 2);
        check_eq("st_pre_top", stack_top, 8'h40);
        check_eq("st_pre_below", stack_belowtop, 8'h11);
        check_eq("st_pre_req", mem_wr_req, 0);
        step(1);
        check_eq("st_req", mem_wr_req, 1);
        check_eq("st_sp", sp, 0);
        check_eq("st_pc", pc, 3);
        n = 0;
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_wr_req !== 1'b1) break;
            n++;
            if (pc !== 8'd3) moved = 1'b1;
            mem_wr_ack = (n == 4);
            @(negedge clk);
        end
        mem_wr_ack = 1'b0;
        check_eq("st_req_cycles", n, 4);
        check_eq("st_pc_moved", moved, 0);
        check_eq("st_after_fetch", fetch_req, 1);
        run = 1'b0;
        step(3);

        // Delay of 3 units at prescale 16; wake mid-delay is ignored
        load_prog(8'h64, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        do_reset();
        run = 1'b1;
        step(2);
        check_eq("dly_exec_opcode", opcode, 8'h64);
        check_eq("dly_exec_fetch", fetch_req, 0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            wake = 1'b0;
            if (fetch_req === 1'b1) break;
            n++;
            if (n == 10) wake = 1'b1;
        end
        wake = 1'b0;
        check_eq("dly_cycles", n, 48);
        check_eq("dly_pc", pc, 1);
        run = 1'b0;
        step(3);

        // Sleep, wake, then a stalled fetch
        load_prog(8'h7A, 8'h35, 8'hFF, 8'hFF, 8'hFF);
        do_reset();
        run = 1'b1;
        step(3);
        check_eq("slp_pc", pc, 1);
        check_eq("slp_fetch", fetch_req, 0);
        left = 1'b0;
        repeat (100) begin
            step(1);
            if (fetch_req || halted) left = 1'b1;
        end
        check_eq("slp_stayed", left, 0);
        ack_en = 1'b0;
        wake = 1'b1;
        step(1);
        wake = 1'b0;
        check_eq("wake_fetch", fetch_req, 1);
        check_eq("wake_pc", pc, 1);
        step(5);
        check_eq("stall_fetch", fetch_req, 1);
        check_eq("stall_opcode", opcode, 8'h7A);
        ack_en = 1'b1;
        step(2);
        check_eq("post_wake_sp", sp, 1);
        check_eq("post_wake_top", stack_top, 8'h35);
        check_eq("post_wake_pc", pc, 2);
        run = 1'b0;
        step(3);

        // '+' on an empty stack
        load_prog(8'h2B, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        do_reset();
        run = 1'b1;
        step(3);
`ifdef SPELL_STACK_CHECK_EN
        check_eq("uf_stack_err", stack_err, 1);
        check_eq("uf_halted", halted, 1);
        check_eq("uf_sp", sp, 0);
        check_eq("uf_pc", pc, 0);
        step(1);
        check_eq("uf_err_clear", stack_err, 0);
        check_eq("uf_restart", halted, 0);
`else
        check_eq("wrap_sp", sp, 31);
        check_eq("wrap_stack_err", stack_err, 0);
        check_eq("wrap_halted", halted, 0);
        check_eq("wrap_pc", pc, 1);
`endif
        run = 1'b0;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
